// File: rtl/monitor_pkg.sv
// Shared types for the RTLola monitor: stream widths, LLC period length
// and the timestamped input event bundle used by the feeder and HLC/LLC.
package monitor_pkg;

    localparam int NUM_STAGES = 5;
    localparam int VAL_W      = 64;
    localparam int TIME_W     = 64;

    typedef struct packed {
        logic                    a;
        logic                    new_a;
        logic                    b;
        logic                    new_b;
        logic signed [VAL_W-1:0] id;
        logic                    new_id;
        logic [TIME_W-1:0]       time_stamp;
    } event_t;

    // An event carrying no fresh stream value is not worth a queue slot.
    function automatic logic has_new(input event_t e);
        return e.new_a | e.new_b | e.new_id;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO of event_t with occupancy count.
// Ports: clk, rst (async, active-high), push_i/wdata_i, pop_i/rdata_o
// (head, valid when !empty_o), full_o, empty_o, level_o.
module event_fifo
    import monitor_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  event_t                 wdata_i,
    input  logic                   pop_i,
    output event_t                 rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    event_t        mem_q [DEPTH];
    logic   [AW:0] wr_q, wr_d;
    logic   [AW:0] rd_q, rd_d;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit tells a full queue apart from an empty one.
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign level_o = wr_q - rd_q;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/monitor_event_feeder.sv
// Monitor input stage: buffers and timestamps environment events and
// presents at most one per LLC period, aligned to stage 0.
// Ports: clk, rst (async, active-high), en; ev_valid/ev_ready handshake
// with ev_* values and presence flags; input_*/new_input_* and
// input_time to the monitor; stage (LLC stage), level (queue occupancy).
module monitor_event_feeder #(
    parameter int NUM_STAGES = monitor_pkg::NUM_STAGES,
    parameter int DEPTH      = 4,
    parameter int VAL_W      = monitor_pkg::VAL_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          ev_valid,
    output logic                          ev_ready,
    input  logic                          ev_a,
    input  logic                          ev_new_a,
    input  logic                          ev_b,
    input  logic                          ev_new_b,
    input  logic signed [VAL_W-1:0]       ev_id,
    input  logic                          ev_new_id,
    output logic                          input_a,
    output logic                          new_input_a,
    output logic                          input_b,
    output logic                          new_input_b,
    output logic signed [VAL_W-1:0]       input_id,
    output logic                          new_input_id,
    output logic [63:0]                   input_time,
    output logic [$clog2(NUM_STAGES)-1:0] stage,
    output logic [$clog2(DEPTH):0]        level
);

    import monitor_pkg::*;

    localparam int SW = $clog2(NUM_STAGES);
    localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);

    logic [SW-1:0] stage_q, stage_d;
    logic [63:0]   time_q, time_d;
    event_t        out_q, out_d;
    event_t        wr_ev;
    event_t        head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign ev_ready = en & ~full;

    always_comb begin
        wr_ev            = '0;
        wr_ev.a          = ev_a;
        wr_ev.new_a      = ev_new_a;
        wr_ev.b          = ev_b;
        wr_ev.new_b      = ev_new_b;
        wr_ev.id         = ev_id;
        wr_ev.new_id     = ev_new_id;
        wr_ev.time_stamp = time_q;
    end

    // Accepted events with no fresh value are consumed without queuing.
    assign push = ev_valid & ev_ready & has_new(wr_ev);
    assign pop  = en & (stage_q == LAST) & ~empty;

    event_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .wdata_i(wr_ev),
        .pop_i  (pop),
        .rdata_o(head),
        .full_o (full),
        .empty_o(empty),
        .level_o(level)
    );

    always_comb begin
        stage_d = stage_q;
        time_d  = time_q;
        out_d   = out_q;
        if (en) begin
            stage_d = (stage_q == LAST) ? '0 : stage_q + 1'b1;
            time_d  = time_q + 64'd1;
            if (pop) begin
                out_d = head;
            end else begin
                // Values hold; only the one-cycle presence pulse drops.
                out_d.new_a  = 1'b0;
                out_d.new_b  = 1'b0;
                out_d.new_id = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            time_q  <= '0;
            out_q   <= '0;
        end else begin
            stage_q <= stage_d;
            time_q  <= time_d;
            out_q   <= out_d;
        end
    end

    assign stage        = stage_q;
    assign input_a      = out_q.a;
    assign new_input_a  = out_q.new_a;
    assign input_b      = out_q.b;
    assign new_input_b  = out_q.new_b;
    assign input_id     = out_q.id;
    assign new_input_id = out_q.new_id;
    assign input_time   = out_q.time_stamp;

endmodule

// File: tb/tb_monitor_event_feeder.sv
// Directed bench for monitor_event_feeder: scoreboard of accepted events
// checked against each new_input_* pulse, plus reset/en/backpressure cases.
module tb_monitor_event_feeder;

    import monitor_pkg::*;

    localparam int NS = 5;

    logic               clk;
    logic               rst;
    logic               en;
    logic               ev_valid;
    logic               ev_ready;
    logic               ev_a;
    logic               ev_new_a;
    logic               ev_b;
    logic               ev_new_b;
    logic signed [63:0] ev_id;
    logic               ev_new_id;
    logic               input_a;
    logic               new_input_a;
    logic               input_b;
    logic               new_input_b;
    logic signed [63:0] input_id;
    logic               new_input_id;
    logic [63:0]        input_time;
    logic [2:0]         stage;
    logic [2:0]         level;

    int          n_tests;
    int          n_fail;
    int          mstage;
    logic [63:0] tmodel;
    logic        acc;
    int          sent;
    logic [2:0]  lvl_save;
    logic [2:0]  stg_save;
    event_t      exp_q[$];

    monitor_event_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_a        (ev_a),
        .ev_new_a    (ev_new_a),
        .ev_b        (ev_b),
        .ev_new_b    (ev_new_b),
        .ev_id       (ev_id),
        .ev_new_id   (ev_new_id),
        .input_a     (input_a),
        .new_input_a (new_input_a),
        .input_b     (input_b),
        .new_input_b (new_input_b),
        .input_id    (input_id),
        .new_input_id(new_input_id),
        .input_time  (input_time),
        .stage       (stage),
        .level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        event_t e;
        if (new_input_a || new_input_b || new_input_id) begin
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_a", 64'(input_a), 64'(e.a));
                chk("out_new_a", 64'(new_input_a), 64'(e.new_a));
                chk("out_b", 64'(input_b), 64'(e.b));
                chk("out_new_b", 64'(new_input_b), 64'(e.new_b));
                chk("out_id", input_id, e.id);
                chk("out_new_id", 64'(new_input_id), 64'(e.new_id));
                chk("out_time", input_time, e.time_stamp);
                chk("pulse_stage", 64'(stage), 64'd0);
            end
        end
    endtask

    task automatic step();
        event_t e;
        #1;
        acc = ev_valid && ev_ready;
        if (acc && (ev_new_a || ev_new_b || ev_new_id)) begin
            e            = '0;
            e.a          = ev_a;
            e.new_a      = ev_new_a;
            e.b          = ev_b;
            e.new_b      = ev_new_b;
            e.id         = ev_id;
            e.new_id     = ev_new_id;
            e.time_stamp = tmodel;
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (en && !rst) begin
            tmodel = tmodel + 64'd1;
            mstage = (mstage == NS - 1) ? 0 : mstage + 1;
        end
        #1;
        chk("stage", 64'(stage), 64'(mstage));
        check_out();
    endtask

    task automatic set_ev(input int k);
        logic [31:0] kk;
        kk        = 32'(k);
        ev_a      = kk[0];
        ev_new_a  = 1'b1;
        ev_b      = kk[1];
        ev_new_b  = kk[0];
        ev_id     = {32'hDEAD_0000, kk};
        ev_new_id = 1'b1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        mstage    = 0;
        tmodel    = '0;
        acc       = 1'b0;
        rst       = 1'b1;
        en        = 1'b0;
        ev_valid  = 1'b0;
        ev_a      = 1'b0;
        ev_new_a  = 1'b0;
        ev_b      = 1'b0;
        ev_new_b  = 1'b0;
        ev_id     = '0;
        ev_new_id = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // reset state
        chk("rst_stage", 64'(stage), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_new_a", 64'(new_input_a), 64'd0);
        chk("rst_input_id", input_id, 64'd0);
        chk("rst_time", input_time, 64'd0);
        chk("rst_ready_en0", 64'(ev_ready), 64'd0);
        en = 1'b1;
        #1;
        chk("rst_ready_en1", 64'(ev_ready), 64'd1);

        // single event accepted at stage 3
        repeat (3) step();
        ev_valid  = 1'b1;
        ev_a      = 1'b1;
        ev_new_a  = 1'b1;
        ev_b      = 1'b1;
        ev_new_b  = 1'b1;
        ev_id     = 64'sd1;
        ev_new_id = 1'b0;
        step();
        ev_valid = 1'b0;
        step();
        chk("t1_new_a", 64'(new_input_a), 64'd1);
        chk("t1_new_b", 64'(new_input_b), 64'd1);
        chk("t1_new_id", 64'(new_input_id), 64'd0);
        chk("t1_time", input_time, 64'd3);
        step();
        chk("t1_pulse_end", 64'(new_input_a), 64'd0);

        // back-to-back burst, full queue meets pop cycle
        while (mstage != 0) step();
        ev_valid = 1'b1;
        sent     = 0;
        for (int k = 0; k < 4; k++) begin
            set_ev(k);
            chk("t2_ready", 64'(ev_ready), 64'd1);
            step();
            if (acc) sent++;
        end
        set_ev(sent);
        chk("t2_level_peak", 64'(level), 64'd4);
        chk("t2_ready_full", 64'(ev_ready), 64'd0);
        step();
        chk("t4_level_after_pop", 64'(level), 64'd3);
        chk("t4_ready_after_pop", 64'(ev_ready), 64'd1);
        for (int c = 0; c < 60 && sent < 6; c++) begin
            set_ev(sent);
            step();
            if (acc) sent++;
        end
        chk("t2_all_sent", 64'(sent), 64'd6);
        ev_valid = 1'b0;
        repeat (30) step();
        chk("t2_drained", 64'(exp_q.size()), 64'd0);

        // event with no fresh value is consumed and dropped
        ev_valid  = 1'b1;
        ev_new_a  = 1'b0;
        ev_new_b  = 1'b0;
        ev_new_id = 1'b0;
        lvl_save  = level;
        chk("t3_ready", 64'(ev_ready), 64'd1);
        step();
        chk("t3_accepted", 64'(acc), 64'd1);
        chk("t3_level", 64'(level), 64'(lvl_save));
        ev_valid = 1'b0;
        repeat (6) step();

        // enable low mid-period freezes everything
        while (mstage != 0) step();
        set_ev(9);
        ev_valid = 1'b1;
        step();
        ev_valid = 1'b0;
        en       = 1'b0;
        stg_save = stage;
        lvl_save = level;
        #1;
        chk("t5_ready_en0", 64'(ev_ready), 64'd0);
        repeat (7) begin
            step();
            chk("t5_stage_frozen", 64'(stage), 64'(stg_save));
            chk("t5_level_frozen", 64'(level), 64'(lvl_save));
            chk("t5_ready_frozen", 64'(ev_ready), 64'd0);
        end
        en = 1'b1;
        step();
        chk("t5_resume_stage", 64'(stage), 64'(stg_save) + 64'd1);
        repeat (10) step();
        chk("t5_drained", 64'(exp_q.size()), 64'd0);

        // asynchronous reset with two events queued
        while (mstage != 0) step();
        ev_valid = 1'b1;
        set_ev(7);
        step();
        set_ev(10);
        step();
        ev_valid = 1'b0;
        chk("t6_level_pre", 64'(level), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_stage", 64'(stage), 64'd0);
        chk("t6_input_a", 64'(input_a), 64'd0);
        chk("t6_input_id", input_id, 64'd0);
        chk("t6_time", input_time, 64'd0);
        exp_q.delete();
        tmodel = '0;
        mstage = 0;
        #2;
        rst = 1'b0;
        repeat (12) step();
        chk("t6_no_stale", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/monitor_event_feeder.md
# monitor_event_feeder

Upstream input stage of the RTLola hardware monitor: accepts input-stream events from the environment over a valid/ready handshake, buffers and timestamps them, and presents at most one event per monitor period to the monitor's `new_input_*` ports, aligned to LLC stage 0. It owns the LLC stage counter, which advances every enabled clock and wraps after `NUM_STAGES` cycles, so stage alignment is guaranteed by construction rather than by testbench timing.

## Interface
- `NUM_STAGES`, 5, LLC clocks per monitor period; ≥2.
- `DEPTH`, 4, event queue entries; power of two, ≥2.
- `VAL_W`, 64, width of signed stream `id`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  global enable; when low every register holds.
- `ev_valid`  in  1  event offered.
- `ev_ready`  out  1  event accepted this cycle when `ev_valid & ev_ready`.
- `ev_a`, `ev_new_a`, `ev_b`, `ev_new_b`  in  1 each  boolean stream values and their presence flags.
- `ev_id`  in  VAL_W  signed stream value; `ev_new_id`  in  1  its presence flag.
- `input_a`, `new_input_a`, `input_b`, `new_input_b`, `input_id`, `new_input_id`  out  1/1/1/1/VAL_W/1  to monitor.
- `input_time`  out  64  cycle timestamp of the presented event.
- `stage`  out  ⌈log2 NUM_STAGES⌉  current LLC stage.
- `level`  out  ⌈log2 DEPTH⌉+1  queue occupancy.

## Operation
- `ev_ready = en & ~full`. Combinational from registered state only; not from `ev_valid`.
- On accept: if any `ev_new_*` is set, enqueue {values, flags, `time_q`}. If none is set, the event is consumed and dropped.
- `time_q`: 64-bit free-running counter, +1 per enabled clock, wraps 2^64−1→0.
- `stage`: 0→1→…→NUM_STAGES−1→0, one step per enabled clock.
- Pop rule: in an enabled cycle with `stage == NUM_STAGES−1` and queue non-empty, pop the head into the output registers. Flags load from the entry, so `new_input_*` are high during the following cycle (`stage == 0`) only.
- In every other enabled cycle, `new_input_*` load 0 and value outputs hold their last value.
- Push and pop in the same cycle are both performed. `full` is the pre-pop value, so a full queue refuses a push even while popping.
- No bypass: an event accepted in the pop cycle itself is not presented until the next period.
- `en` low: stage, time, queue, and outputs hold; `ev_ready = 0`. If `en` drops while `new_input_*` are high, they remain high until the next enabled clock clears them.

## Timing
- Reset values: `stage` 0, `time_q` 0, queue empty (`level` 0), all `input_*`/`new_input_*` 0, `input_time` 0. Hence `ev_ready = en` after reset.
- Reset asserted mid-operation discards all queued events immediately (asynchronous). The first enabled clock after deassertion sees `stage` 0.
- Minimum latency is 2 clocks, from accept (at `stage == NUM_STAGES−2`) to `new_input_*` high.
- Maximum latency with an empty queue is NUM_STAGES+1 clocks.
- Throughput: one event per NUM_STAGES clocks. A sustained faster source backpressures via `ev_ready`.
- `input_time` = value of `time_q` in the accept cycle.

## Structure
- Shared package `monitor_pkg`:
  - `NUM_STAGES`;
  - `VAL_W`;
  - `event_t` struct {a, new_a, b, new_b, id, new_id, time[63:0]}.
  The HLC/LLC side uses the same package.
- Sub-module `event_fifo`: synchronous FIFO of `event_t`, DEPTH entries, async active-high reset, push/pop/full/empty/level. Pointers are one bit wider than the index for full/empty.
- Top level holds the stage counter, the time counter, the pop logic, and the output registers.

## Test plan
- Reset, `en=1`, one event {a=1,new_a=1,b=1,new_b=1,id=1,new_id=0} accepted at stage 3 → `new_input_a`/`new_input_b` high exactly at the next stage 0, `new_input_id` 0, `input_time` = 3.
- Six back-to-back events offered with `ev_valid` held high → the first 4 are accepted before any pop, then `ev_ready` is 0. Events appear in order, one per 5 clocks, at stage 0 only; `level` peaks at 4.
- Event with all `new_*` = 0 → accepted, `level` unchanged, no `new_input_*` pulse.
- Queue full and pop cycle coincide with `ev_valid=1` → pop occurs, push refused, `level` = 3 next cycle, `ev_ready` = 1 in that next cycle.
- `en` low for 7 clocks mid-period → `stage`, `time_q` and `level` are frozen and `ev_ready` = 0. Resuming continues from the frozen stage.
- `rst` pulse between clock edges with 2 events queued → outputs and `level` go to 0 immediately. No stale event is presented after release.
